fetch_step_ctrl: RTL

Sequencer for the instruction-fetch datapath. It owns the PC, issues fetch requests to instruction memory over a req/ack handshake, latches the returned word, and runs in free-run or single-step mode. It also schedules the 8-bit LED bank across the four instruction bytes, by manual select or auto-scan. It sits between the board buttons/switches, the instruction memory and the LED pins.

---
 rtl/fetch_step_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fetch_step_ctrl.sv
// Instruction-fetch sequencer: PC, req/ack fetch, halt/fault handling,
// single-step / free-run control and a byte-multiplexed LED display.
module fetch_step_ctrl #(
    parameter int          ADDR_W    = 8,
    parameter int          PC_INC    = 4,
    parameter logic [31:0] HALT_CODE = 32'hFFFF_FFFF,
    parameter int          TIMEOUT   = 16,
    parameter int          SCAN_DIV  = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              auto_scan,
    input  logic [1:0]        choose,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       inst_code,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [1:0]        byte_idx,
    output logic [7:0]        LED
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        LATCH,
        HALT
    } state_t;

    state_t            state;
    state_t            state_n;
    logic              step_q;
    logic              step_hit;
    logic [WAIT_W-1:0] wait_cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic              is_halt_word;

    assign mem_addr     = pc;
    assign is_halt_word = (inst_code == HALT_CODE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        mem_req = 1'b0;
        busy    = 1'b0;
        halted  = 1'b0;
        unique case (state)
            IDLE: begin
                if (run || step_hit) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_ack) begin
                    state_n = LATCH;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n = HALT;
                end
            end
            LATCH: begin
                busy    = 1'b1;
                state_n = is_halt_word ? HALT : IDLE;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Step edge is registered, so it only counts if it lands while IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q    <= 1'b0;
            step_hit  <= 1'b0;
            wait_cnt  <= '0;
            inst_code <= '0;
            fault     <= 1'b0;
            pc        <= '0;
        end else begin
            step_q   <= step;
            step_hit <= step & ~step_q;
            if (state == REQ) begin
                if (mem_ack) begin
                    inst_code <= mem_rdata;
                    wait_cnt  <= '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    fault    <= 1'b1;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
            if (state == LATCH && !is_halt_word) begin
                pc <= pc + ADDR_W'(PC_INC);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            byte_idx <= 2'd0;
            LED      <= 8'h00;
        end else begin
            if (auto_scan) begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt <= '0;
                    byte_idx <= byte_idx + 2'd1;
                end else begin
                    scan_cnt <= scan_cnt + 1'b1;
                end
            end else begin
                scan_cnt <= '0;
                byte_idx <= choose;
            end
            LED <= fault ? 8'hEE : inst_code[{byte_idx, 3'b000} +: 8];
        end
    end

endmodule
